// File: rtl/sub_serial_n.sv
// Bit-serial n-bit subtractor.
// One bit per clock, LSB first. Operands are latched on the start edge.
// The result, unsigned borrow and signed overflow are registered on the
// edge that processes the MSB and stay put until the next result lands.
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | waiting for start_i; operands latched on the accepting edge
// RUN   | one operand bit per edge, bit n-1 processed on the last RUN edge
// DONE  | result registered, done_o high for this one cycle

module sub_serial_n #(
   parameter int n = 8
) (
   input  logic         clk_i,
   input  logic         rst_ni,
   input  logic         start_i,
   input  logic [n-1:0] data0_i,
   input  logic [n-1:0] data1_i,
   output logic         busy_o,
   output logic         done_o,
   output logic [n-1:0] diff_o,
   output logic         borrow_o,
   output logic         over_o
);

   localparam int CW = $clog2(n) + 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t         state;
   state_t         state_nxt;

   // Operand registers rotate rather than shift, so on the last RUN edge
   // bit 0 holds the original MSB needed for the overflow term.
   logic [n-1:0]   a_sr;
   logic [n-1:0]   b_sr;
   // Partial result: the upper n-1 bits gathered so far, MSB side first.
   logic [n-2:0]   res_sr;
   logic [n-1:0]   res_cat;
   logic           bw;
   logic [CW-1:0]  cnt;

   logic           a_bit;
   logic           b_bit;
   logic           d_bit;
   logic           bw_nxt;
   logic           last_bit;

   assign a_bit    = a_sr[0];
   assign b_bit    = b_sr[0];
   assign d_bit    = a_bit ^ b_bit ^ bw;
   assign bw_nxt   = (~a_bit & b_bit) | (~(a_bit ^ b_bit) & bw);
   assign last_bit = (cnt == CW'(n - 1));
   assign res_cat  = {d_bit, res_sr};

   assign busy_o   = (state != IDLE);
   assign done_o   = (state == DONE);

   // State register.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state logic; start_i only matters in IDLE.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: if (start_i)  state_nxt = RUN;
         RUN:  if (last_bit) state_nxt = DONE;
         DONE: state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Serial datapath and registered result.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         a_sr     <= '0;
         b_sr     <= '0;
         res_sr   <= '0;
         bw       <= 1'b0;
         cnt      <= '0;
         diff_o   <= '0;
         borrow_o <= 1'b0;
         over_o   <= 1'b0;
      end else if (state == IDLE) begin
         if (start_i) begin
            a_sr <= data0_i;
            b_sr <= data1_i;
            bw   <= 1'b0;
            cnt  <= '0;
         end
      end else if (state == RUN) begin
         a_sr   <= {a_sr[0], a_sr[n-1:1]};
         b_sr   <= {b_sr[0], b_sr[n-1:1]};
         res_sr <= res_cat[n-1:1];
         bw     <= bw_nxt;
         if (last_bit) begin
            diff_o   <= res_cat;
            borrow_o <= bw_nxt;
            over_o   <= (a_bit ^ b_bit) & (a_bit ^ d_bit);
         end else begin
            cnt <= cnt + 1'b1;
         end
      end
   end

endmodule

// File: doc/sub_serial_n.md
SUB_SERIAL_N -- requirements
Module: sub_serial_n

Interface
REQ-001 SHALL have parameter n, default 8, meaning operand and result width in bits; legal range n >= 2.
REQ-002 SHALL have port clk_i, input, 1 bit, meaning the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_ni, input, 1 bit, meaning asynchronous active-low reset.
REQ-004 SHALL have port start_i, input, 1 bit, meaning a request to begin one subtraction.
REQ-005 SHALL have port data0_i, input, n bits, meaning the minuend.
REQ-006 SHALL have port data1_i, input, n bits, meaning the subtrahend.
REQ-007 SHALL have port busy_o, output, 1 bit, meaning an operation is in progress (state not IDLE).
REQ-008 SHALL have port done_o, output, 1 bit, meaning a single-cycle pulse that marks a completed result.
REQ-009 SHALL have port diff_o, output, n bits, meaning the registered result data0_i - data1_i, modulo 2^n.
REQ-010 SHALL have port borrow_o, output, 1 bit, meaning the registered unsigned borrow, i.e. data0_i < data1_i.
REQ-011 SHALL have port over_o, output, 1 bit, meaning the registered two's-complement signed overflow.

Function
REQ-012 SHALL implement a three-state machine with states IDLE, RUN and DONE.
REQ-013 SHALL, in IDLE on an edge where start_i=1, latch data0_i and data1_i into internal shift registers, clear the borrow flip-flop to 0, clear the bit counter to 0, and go to RUN.
REQ-014 SHALL, in RUN, process exactly one bit per edge, LSB first.
- d = a ^ b ^ bw
- bw_next = (~a & b) | (~(a ^ b) & bw)
- d is shifted into the result register from the MSB side.
REQ-015 SHALL, on the edge that processes bit n-1 (edge Tn, where T0 is the start edge), load diff_o, borrow_o and over_o and go to DONE.
- borrow_o = final bw
- over_o = (a[n-1] ^ b[n-1]) & (a[n-1] ^ diff[n-1]), using the latched operands.
REQ-016 SHALL hold done_o=1 for exactly the one cycle spent in DONE, then return to IDLE on the next edge.
- Latency: done_o rises n cycles after the start edge.
- Throughput: one result per n+2 cycles.
REQ-017 SHALL ignore start_i while in RUN or DONE; there is no queueing and the in-flight operation is unaffected.
REQ-018 SHALL keep the latched operands unaffected by any change on data0_i or data1_i after T0.
REQ-019 SHALL hold diff_o, borrow_o and over_o stable until the next Tn; starting a new operation does not clear them.
REQ-020 SHALL drive busy_o=1 exactly when the state is RUN or DONE.
REQ-021 SHALL size the bit counter to $clog2(n)+1 bits and SHALL NOT let it wrap within one operation.

Reset
REQ-022 SHALL, when rst_ni=0, immediately and independently of clk_i, force the following:
- state = IDLE
- busy_o = 0, done_o = 0
- diff_o = 0, borrow_o = 0, over_o = 0
- counter, borrow flip-flop and shift registers = 0
REQ-023 SHALL, on reset during RUN or DONE, abort the operation with no done_o pulse; a start_i sampled on the first edge after rst_ni rises SHALL be accepted normally.

Verification (n=8)
REQ-024 SHALL cover: start with 0x50 - 0x30 -> done_o pulses exactly 8 cycles after the start edge; diff_o=0x20, borrow_o=0, over_o=0; busy_o high for 9 cycles.
REQ-025 SHALL cover: 0x30 - 0x50 -> diff_o=0xE0, borrow_o=1, over_o=0.
REQ-026 SHALL cover: 0x80 - 0x01 -> diff_o=0x7F, borrow_o=0, over_o=1; and 0x7F - 0xFF -> diff_o=0x80, borrow_o=1, over_o=1.
REQ-027 SHALL cover: start 0x10 - 0x01, then hold start_i=1 with data 0xFF/0xFF for the whole operation -> result 0x0F only; the second start is accepted only after return to IDLE, giving diff_o=0x00, borrow_o=0.
REQ-028 SHALL cover: rst_ni pulsed low 4 cycles into RUN -> all outputs go to 0 at once and no done_o pulse occurs; a following start with 0x05 - 0x03 -> diff_o=0x02 after 8 cycles.
REQ-029 SHALL cover: back-to-back operations -> diff_o holds the previous value throughout the second RUN and updates only at the second Tn.
